// File: rtl/dispatch_queue_pkg.sv
// Shared types and op-class codes for the dispatch queue slice.
// Op-class codes match the decoder's operaType encoding for the classes routed to the LSB.
package dispatch_queue_pkg;

  localparam logic [2:0] SType     = 3'd3;
  localparam logic [2:0] ILoadType = 3'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } dq_entry_t;

  // Memory-class ops go to the LSB; everything else goes to the RS.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == SType) || (op == ILoadType);
  endfunction

endpackage

// File: rtl/dispatch_queue_mem.sv
// DEPTH x 65-bit entry storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the owner's count.
module dispatch_queue_mem
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk_in,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  dq_entry_t       i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output dq_entry_t       o_rdata
);

  dq_entry_t r_mem [DEPTH];

  // Entry write on push.
  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dispatch_queue.sv
// Instruction queue between fetch and issue with registered ROB/RS/LSB dispatch.
// Optional same-cycle empty-queue bypass: define DISPATCH_QUEUE_BYPASS_EN.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int   DEPTH       = 32,
  parameter int   AFULL_SLACK = 2,
  localparam int  AW          = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          roll_back,
  input  logic          instruction_ready,
  input  logic [31:0]   instruction_in,
  input  logic [31:0]   pc_in,
  input  logic          pred_taken_in,
  input  logic [2:0]    op_type_in,
  input  logic          rob_is_full,
  input  logic          rs_is_full,
  input  logic          lsb_is_full,
  output logic [31:0]   head_instruction,
  output logic          head_valid,
  output logic          ins_to_rob,
  output logic          ins_to_rs,
  output logic          ins_to_lsb,
  output logic [31:0]   instruction_out,
  output logic [31:0]   ins_pc_out,
  output logic          pred_taken_out,
  output logic          is_full,
  output logic          almost_full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] SLACK_C = (AW+1)'(AFULL_SLACK);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_rear;
  logic [AW:0]   r_count;
  logic          r_to_rob;
  logic          r_to_rs;
  logic          r_to_lsb;
  logic [31:0]   r_instr;
  logic [31:0]   r_pc;
  logic          r_pred;

  dq_entry_t     w_rd_entry;
  dq_entry_t     w_wr_entry;
  dq_entry_t     w_head_entry;
  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_head_valid;
  logic          w_mem_op;
  logic          w_can_pop;
  logic          w_pop_q;
  logic          w_push;
  logic          w_we;
  logic [AW:0]   w_count_nxt;

  dispatch_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_in  (clk_in),
    .i_we    (w_we),
    .i_waddr (r_rear),
    .i_wdata (w_wr_entry),
    .i_raddr (r_head),
    .o_rdata (w_rd_entry)
  );

  assign w_wr_entry = {instruction_in, pc_in, pred_taken_in};
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);

`ifdef DISPATCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && instruction_ready && rdy_in && !roll_back;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_head_entry = w_bypass ? w_wr_entry : w_rd_entry;
  assign w_head_valid = !w_empty || w_bypass;
  assign w_mem_op     = is_mem_op(op_type_in);
  assign w_can_pop    = w_head_valid && !rob_is_full &&
                        (w_mem_op ? !lsb_is_full : !rs_is_full);
  assign w_pop_q      = w_can_pop && !w_empty;
  // A bypassed entry that dispatches immediately never enters storage.
  assign w_push       = instruction_ready && (!w_full || w_pop_q) &&
                        !(w_bypass && w_can_pop);
  assign w_we         = w_push && rdy_in && !roll_back && !rst_in;

  // Occupancy update: push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop_q})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy, dispatch strobes and payload.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head   <= '0;
      r_rear   <= '0;
      r_count  <= '0;
      r_to_rob <= 1'b0;
      r_to_rs  <= 1'b0;
      r_to_lsb <= 1'b0;
      r_instr  <= 32'd0;
      r_pc     <= 32'd0;
      r_pred   <= 1'b0;
    end else if (roll_back) begin
      r_head   <= '0;
      r_rear   <= '0;
      r_count  <= '0;
      r_to_rob <= 1'b0;
      r_to_rs  <= 1'b0;
      r_to_lsb <= 1'b0;
    end else if (!rdy_in) begin
      r_to_rob <= 1'b0;
      r_to_rs  <= 1'b0;
      r_to_lsb <= 1'b0;
    end else begin
      if (w_push) begin
        r_rear <= r_rear + AW'(1);
      end
      if (w_pop_q) begin
        r_head <= r_head + AW'(1);
      end
      r_count  <= w_count_nxt;
      r_to_rob <= w_can_pop;
      r_to_rs  <= w_can_pop && !w_mem_op;
      r_to_lsb <= w_can_pop && w_mem_op;
      if (w_can_pop) begin
        r_instr <= w_head_entry.instr;
        r_pc    <= w_head_entry.pc;
        r_pred  <= w_head_entry.pred;
      end
    end
  end

  assign head_instruction = w_head_entry.instr;
  assign head_valid       = w_head_valid;
  assign ins_to_rob       = r_to_rob;
  assign ins_to_rs        = r_to_rs;
  assign ins_to_lsb       = r_to_lsb;
  assign instruction_out  = r_instr;
  assign ins_pc_out       = r_pc;
  assign pred_taken_out   = r_pred;
  assign is_full          = w_full;
  assign almost_full      = (DEPTH_C - r_count) <= SLACK_C;
  assign count            = r_count;

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised instruction queue between fetch (icache/memory interface) and issue (ROB, RS, LSB). Buffers fetched instruction/PC/prediction triples in a power-of-two circular buffer, presents the head entry to the decoder, and, after the decoder classifies it, dispatches it with registered strobes to ROB plus either RS or LSB. Generalises the fixed 32-entry queue: configurable depth, count-based full/empty, almost-full back-pressure, a predicted-taken sideband and a registered dispatch payload that stays aligned with its strobes.

## Interface
- DEPTH, 32, entry count; power of two, at least 4
- AW, $clog2(DEPTH), pointer width; derived, not overridden
- AFULL_SLACK, 2, almost_full asserts when free entries are at most this value
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global ready; low pauses the block
- roll_back  in  1  misprediction flush
- instruction_ready  in  1  push strobe from fetch
- instruction_in  in  32  fetched instruction
- pc_in  in  32  PC of fetched instruction
- pred_taken_in  in  1  BTB prediction for this PC
- op_type_in  in  3  decoder class of head_instruction (operaType.v encoding)
- rob_is_full / rs_is_full / lsb_is_full  in  1 each  downstream back-pressure
- head_instruction  out  32  combinational head entry, to decoder
- head_valid  out  1  queue non-empty
- ins_to_rob / ins_to_rs / ins_to_lsb  out  1 each  registered one-cycle dispatch strobes
- instruction_out / ins_pc_out  out  32 each  registered payload of the dispatched entry
- pred_taken_out  out  1  registered prediction of the dispatched entry
- is_full  out  1  count == DEPTH
- almost_full  out  1  DEPTH − count ≤ AFULL_SLACK
- count  out  AW+1  occupancy

## Operation
- State: mem[DEPTH] of {instr, pc, pred}; head, rear (AW bits, natural wrap); count (AW+1 bits).
- Priority per edge: rst_in > roll_back > !rdy_in > normal.
- Reset: head=rear=count=0; all strobes 0; payload outputs 0.
- roll_back (rdy_in ignored): head=rear=count=0, strobes 0, same-cycle push discarded. Payload registers keep previous values.
- rdy_in low: all state held; strobes forced 0.
- Push: instruction_ready && (!is_full || pop) writes mem[rear], rear+1. Push while full with no pop is ignored, no pointer change.
- Pop decision (head_valid): op_type_in ∈ {SType, ILoadType} → needs !rob_is_full && !lsb_is_full, sets ins_to_rob, ins_to_lsb; otherwise needs !rob_is_full && !rs_is_full, sets ins_to_rob, ins_to_rs. On pop: head+1, payload registers load mem[head]. Blocked or empty: all strobes 0, payload held.
- count: +1 on push only, −1 on pop only, unchanged on both.
- Strobes are mutually consistent: ins_to_rob equals ins_to_rs | ins_to_lsb; rs and lsb never both 1.

## Timing
- Push-to-visible: entry written at edge N shows on head_instruction after edge N (one cycle, without bypass).
- Dispatch: strobes and payload valid the cycle after the decision edge, for exactly one cycle per entry; maximum throughput one entry per cycle.
- is_full/almost_full/count/head_valid are combinational from registered state; fetch must see them before pushing.
- Full with simultaneous push and pop: both occur, count stays DEPTH.
- Pointer wrap DEPTH−1 → 0 is seamless; empty and full distinguished by count only.

## Configuration
- DISPATCH_QUEUE_BYPASS_EN defined: when count==0 and instruction_ready, head_instruction/head_valid are driven from instruction_in in the same cycle; if the pop condition holds, the entry is dispatched directly to the payload registers without a mem write; rear, head and count are unchanged. Roll_back and !rdy_in suppress the bypass.
- Undefined: no bypass; minimum push-to-strobe latency two edges.

## Structure
- operaType.v (shared header): `TRUE/`FALSE, op-type codes SType, ILoadType; no new codes added here.
- One sub-module, dispatch_queue_mem: DEPTH×65-bit storage, one write port, one asynchronous read port; no reset on contents.
- Pointer, count, routing and strobe logic stay in dispatch_queue.

## Test plan
- Reset mid-stream with 5 entries → next cycle count=0, head_valid=0, all strobes 0.
- DEPTH=4: push 4 with rob_is_full=1 → is_full=1, almost_full=1 from count=2; fifth push ignored; release ROB → 4 in-order dispatches, consecutive strobes, ins_pc_out 0x0,0x4,0x8,0xC.
- Alternating op_type SType/RType with rs_is_full=1 → SType dispatches (rob+lsb), RType stalls head; later entries do not overtake.
- Full queue, push and pop same cycle → count stays 4, new entry dispatched 4 pops later with correct pred_taken_out.
- roll_back coinciding with push and pop → count=0, strobes 0 next cycle, pushed entry never dispatched.
- rdy_in low 3 cycles during streaming → no strobes, count frozen; resumes without loss or duplication; with DISPATCH_QUEUE_BYPASS_EN, empty-queue push of 0x00000013 yields ins_to_rs=1 the next cycle, count stays 0.
